// File: rtl/cfu_simd_mac_if.sv
// Custom-instruction port between the CPU (master) and the CFU (slave).
// Command and response channels each use a valid/ready handshake.
interface cfu_simd_mac_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_payload_function_id;
    logic [DATA_W-1:0] cmd_payload_inputs_0;
    logic [DATA_W-1:0] cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_simd_mac.sv
// CFU front-end with a packed-SIMD multiply-accumulate engine, persistent
// accumulator, programmable input offset and sticky error flag.
//
// state  | meaning
// S_IDLE | cmd_ready high, waiting for a command
// S_BUSY | MAC in flight, counting down remaining latency
// S_RESP | rsp_valid high, payload held until rsp_ready
module cfu_simd_mac #(
    parameter int DATA_W      = 32,
    parameter int ELEM_W      = 8,
    parameter int ACC_W       = 32,
    parameter int MAC_LATENCY = 2,
    parameter int SATURATE    = 0
) (
    input  logic          clk,
    input  logic          reset,
    cfu_simd_mac_if.slave bus
);
    localparam int LANES  = DATA_W / ELEM_W;
    localparam int PROD_W = 2 * ELEM_W + 2;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int CNT_W  = $clog2(MAC_LATENCY + 1);

    localparam logic [6:0] OP_CLEAR  = 7'd0;
    localparam logic [6:0] OP_OFFSET = 7'd1;
    localparam logic [6:0] OP_MAC    = 7'd2;
    localparam logic [6:0] OP_READ   = 7'd3;
    localparam logic [6:0] OP_LOAD   = 7'd4;
    localparam logic [6:0] OP_STATUS = 7'd5;

    localparam logic signed [EXT_W-1:0] ACC_MAX =
        {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN =
        {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [ACC_W-1:0]          acc;
    logic signed [ELEM_W:0]    offset;
    logic                      err;
    logic [DATA_W-1:0]         a_q;
    logic [DATA_W-1:0]         b_q;
    logic signed [ELEM_W:0]    off_q;
    logic                      cmd_ready_q;
    logic                      rsp_valid_q;
    logic [DATA_W-1:0]         rsp_data_q;

    logic                      accept;
    logic [6:0]                funct7;
    logic [DATA_W-1:0]         mac_a;
    logic [DATA_W-1:0]         mac_b;
    logic signed [ELEM_W:0]    mac_off;
    logic [ELEM_W-1:0]         a_el;
    logic [ELEM_W-1:0]         b_el;
    logic signed [PROD_W-1:0]  a_off;
    logic signed [PROD_W-1:0]  b_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [SUM_W-1:0]   lane_sum;
    logic signed [EXT_W-1:0]   acc_ext;
    logic [ACC_W-1:0]          mac_acc;

    assign bus.cmd_ready             = cmd_ready_q;
    assign bus.rsp_valid             = rsp_valid_q;
    assign bus.rsp_payload_outputs_0 = rsp_data_q;

    assign accept = bus.cmd_valid && cmd_ready_q;
    assign funct7 = bus.cmd_payload_function_id[9:3];

    // Single-cycle MAC has no BUSY state, so it must compute straight off the bus.
    assign mac_a   = (MAC_LATENCY == 1) ? bus.cmd_payload_inputs_0 : a_q;
    assign mac_b   = (MAC_LATENCY == 1) ? bus.cmd_payload_inputs_1 : b_q;
    assign mac_off = (MAC_LATENCY == 1) ? offset : off_q;

    function automatic logic [DATA_W-1:0] acc_to_rsp(input logic [ACC_W-1:0] v);
        return {{(DATA_W-ACC_W+1){v[ACC_W-1]}}, v[ACC_W-2:0]};
    endfunction

    always_comb begin
        a_el     = '0;
        b_el     = '0;
        a_off    = '0;
        b_ext    = '0;
        prod     = '0;
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            a_el     = mac_a[i*ELEM_W +: ELEM_W];
            b_el     = mac_b[i*ELEM_W +: ELEM_W];
            a_off    = {{(PROD_W-ELEM_W){a_el[ELEM_W-1]}}, a_el}
                     + {{(PROD_W-ELEM_W-1){mac_off[ELEM_W]}}, mac_off};
            b_ext    = {{(PROD_W-ELEM_W){b_el[ELEM_W-1]}}, b_el};
            prod     = a_off * b_ext;
            lane_sum = lane_sum + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
        acc_ext = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc}
                + {{(EXT_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
        mac_acc = acc_ext[ACC_W-1:0];
        if (SATURATE != 0) begin
            if (acc_ext > ACC_MAX) begin
                mac_acc = ACC_MAX[ACC_W-1:0];
            end else if (acc_ext < ACC_MIN) begin
                mac_acc = ACC_MIN[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            offset      <= '0;
            err         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            off_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        a_q         <= bus.cmd_payload_inputs_0;
                        b_q         <= bus.cmd_payload_inputs_1;
                        off_q       <= offset;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                        case (funct7)
                            OP_CLEAR:  acc    <= '0;
                            OP_OFFSET: offset <= bus.cmd_payload_inputs_0[ELEM_W:0];
                            OP_MAC: begin
                                if (MAC_LATENCY == 1) begin
                                    acc        <= mac_acc;
                                    rsp_data_q <= acc_to_rsp(mac_acc);
                                end else begin
                                    rsp_valid_q <= 1'b0;
                                    cnt         <= CNT_W'((MAC_LATENCY > 1) ? MAC_LATENCY - 2 : 0);
                                    state       <= S_BUSY;
                                end
                            end
                            OP_READ:   rsp_data_q <= acc_to_rsp(acc);
                            OP_LOAD:   acc        <= bus.cmd_payload_inputs_0[ACC_W-1:0];
                            OP_STATUS: begin
                                rsp_data_q <= {{(DATA_W-1){1'b0}}, err};
                                err        <= 1'b0;
                            end
                            default:   err <= 1'b1;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        acc         <= mac_acc;
                        rsp_data_q  <= acc_to_rsp(mac_acc);
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_simd_mac.sv
// Drives two CFU instances (wrap/latency 2 and saturate/latency 3) with the
// same command stream and compares each against an arithmetic reference model.
module tb_cfu_simd_mac;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cfu_simd_mac_if #(.DATA_W(32)) bus0 ();
    cfu_simd_mac_if #(.DATA_W(32)) bus1 ();

    cfu_simd_mac #(.DATA_W(32), .ELEM_W(8), .ACC_W(32), .MAC_LATENCY(2), .SATURATE(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    cfu_simd_mac #(.DATA_W(32), .ELEM_W(8), .ACC_W(32), .MAC_LATENCY(3), .SATURATE(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_acc0, m_acc1;
    int          m_off;
    logic        m_err;

    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [6:0] f7, input logic [31:0] a,
                             input logic [31:0] b);
        logic [2:0] junk;
        junk = 3'($urandom);
        bus0.cmd_valid = v;  bus1.cmd_valid = v;
        bus0.cmd_payload_function_id = {f7, junk};
        bus1.cmd_payload_function_id = {f7, junk};
        bus0.cmd_payload_inputs_0 = a;  bus1.cmd_payload_inputs_0 = a;
        bus0.cmd_payload_inputs_1 = b;  bus1.cmd_payload_inputs_1 = b;
    endtask

    task automatic model_apply(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] e0, output logic [31:0] e1);
        longint sum, t;
        e0 = '0;
        e1 = '0;
        case (f7)
            7'd0: begin m_acc0 = '0; m_acc1 = '0; end
            7'd1: begin
                m_off = int'(a[8:0]);
                if (m_off > 255) m_off -= 512;
            end
            7'd2: begin
                sum = 0;
                for (int i = 0; i < 4; i++)
                    sum += longint'(int'(byte'(a >> (8*i))) + m_off) * longint'(byte'(b >> (8*i)));
                t = longint'($signed(m_acc0)) + sum;
                m_acc0 = t[31:0];
                t = longint'($signed(m_acc1)) + sum;
                if (t > SMAX) t = SMAX;
                else if (t < SMIN) t = SMIN;
                m_acc1 = t[31:0];
                e0 = m_acc0;
                e1 = m_acc1;
            end
            7'd3: begin e0 = m_acc0; e1 = m_acc1; end
            7'd4: begin m_acc0 = a; m_acc1 = a; end
            7'd5: begin e0 = {31'b0, m_err}; e1 = {31'b0, m_err}; m_err = 1'b0; end
            default: m_err = 1'b1;
        endcase
    endtask

    // Issue one command to both DUTs, check latency and payload, optionally
    // stall the response for `hold` cycles while offering a CLEAR that must be ignored.
    task automatic do_cmd(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] got0, output logic [31:0] got1);
        logic [31:0] e0, e1;
        int lat0, lat1, n, elat0, elat1;
        bit seen0, seen1;
        model_apply(f7, a, b, e0, e1);
        elat0 = (f7 == 7'd2) ? 2 : 1;
        elat1 = (f7 == 7'd2) ? 3 : 1;
        drive_cmd(1'b1, f7, a, b);
        n = 0;
        while (!(bus0.cmd_ready && bus1.cmd_ready) && n < 20) begin
            step();
            n++;
        end
        check_val("ready_wait", 32'(n), 32'd0);
        step();
        drive_cmd(1'b0, 7'd0, $urandom, $urandom);
        seen0 = 0; seen1 = 0; lat0 = 0; lat1 = 0; got0 = '0; got1 = '0;
        for (int c = 1; c <= 10 && !(seen0 && seen1); c++) begin
            if (!seen0 && bus0.rsp_valid) begin seen0 = 1; lat0 = c; got0 = bus0.rsp_payload_outputs_0; end
            if (!seen1 && bus1.rsp_valid) begin seen1 = 1; lat1 = c; got1 = bus1.rsp_payload_outputs_0; end
            if (!(seen0 && seen1)) step();
        end
        check_val($sformatf("lat0 f7=%0d", f7), 32'(lat0), 32'(elat0));
        check_val($sformatf("lat1 f7=%0d", f7), 32'(lat1), 32'(elat1));
        check_val($sformatf("rsp0 f7=%0d", f7), got0, e0);
        check_val($sformatf("rsp1 f7=%0d", f7), got1, e1);
        for (int h = 0; h < hold; h++) begin
            drive_cmd(1'b1, 7'd0, $urandom, $urandom);
            step();
            check_val("hold_valid0", 32'(bus0.rsp_valid), 32'd1);
            check_val("hold_valid1", 32'(bus1.rsp_valid), 32'd1);
            check_val("hold_data0", bus0.rsp_payload_outputs_0, e0);
            check_val("hold_data1", bus1.rsp_payload_outputs_0, e1);
            check_val("hold_ready0", 32'(bus0.cmd_ready), 32'd0);
            check_val("hold_ready1", 32'(bus1.cmd_ready), 32'd0);
        end
        drive_cmd(1'b0, 7'd0, '0, '0);
        bus0.rsp_ready = 1'b1;  bus1.rsp_ready = 1'b1;
        step();
        bus0.rsp_ready = 1'b0;  bus1.rsp_ready = 1'b0;
        check_val("post_valid0", 32'(bus0.rsp_valid), 32'd0);
        check_val("post_valid1", 32'(bus1.rsp_valid), 32'd0);
        check_val("post_ready0", 32'(bus0.cmd_ready), 32'd1);
        check_val("post_ready1", 32'(bus1.cmd_ready), 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] g0, g1, ra, rb;
        logic [6:0]  f7;
        int          r;

        m_acc0 = '0; m_acc1 = '0; m_off = 0; m_err = 1'b0;
        reset = 1'b0;
        drive_cmd(1'b0, 7'd0, '0, '0);
        bus0.rsp_ready = 1'b0;  bus1.rsp_ready = 1'b0;
        repeat (3) step();
        check_val("rst_valid0", 32'(bus0.rsp_valid), 32'd0);
        check_val("rst_valid1", 32'(bus1.rsp_valid), 32'd0);
        check_val("rst_data0", bus0.rsp_payload_outputs_0, 32'd0);
        check_val("rst_data1", bus1.rsp_payload_outputs_0, 32'd0);
        reset = 1'b1;
        step();
        check_val("rst_ready0", 32'(bus0.cmd_ready), 32'd1);
        check_val("rst_ready1", 32'(bus1.cmd_ready), 32'd1);

        do_cmd(7'd0, $urandom, $urandom, 0, g0, g1);
        check_val("clear_gold", g0, 32'h0);
        do_cmd(7'd3, $urandom, $urandom, 0, g0, g1);
        check_val("read_gold", g1, 32'h0);

        do_cmd(7'd1, 32'd128, 32'd0, 0, g0, g1);
        do_cmd(7'd2, 32'h0102_0304, 32'h0101_0101, 0, g0, g1);
        check_val("offset_mac_gold0", g0, 32'h0000_020A);
        check_val("offset_mac_gold1", g1, 32'h0000_020A);

        do_cmd(7'd4, 32'h7FFF_FFF0, 32'd0, 0, g0, g1);
        do_cmd(7'd1, 32'd0, 32'd0, 0, g0, g1);
        do_cmd(7'd2, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 0, g0, g1);
        check_val("wrap_gold", g0, 32'h8000_FBF4);
        check_val("sat_pos_gold", g1, 32'h7FFF_FFFF);

        do_cmd(7'd4, 32'h8000_0010, 32'd0, 0, g0, g1);
        do_cmd(7'd2, 32'h8181_8181, 32'h7F7F_7F7F, 0, g0, g1);
        check_val("wrap_neg_gold", g0, 32'h7FFF_040C);
        check_val("sat_neg_gold", g1, 32'h8000_0000);

        do_cmd(7'd3, '0, '0, 5, g0, g1);
        do_cmd(7'd3, '0, '0, 0, g0, g1);
        check_val("held_clear_ignored", g0, 32'h7FFF_040C);

        do_cmd(7'd9, $urandom, $urandom, 0, g0, g1);
        check_val("unknown_gold", g0, 32'h0);
        do_cmd(7'd5, '0, '0, 0, g0, g1);
        check_val("status_set_gold", g0, 32'h1);
        do_cmd(7'd5, '0, '0, 0, g0, g1);
        check_val("status_clr_gold", g1, 32'h0);

        // Reset while a MAC is in BUSY: the response must never appear.
        do_cmd(7'd1, 32'd5, '0, 0, g0, g1);
        drive_cmd(1'b1, 7'd2, 32'h1111_1111, 32'h2222_2222);
        step();
        drive_cmd(1'b0, 7'd0, '0, '0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("busy_rst_valid0", 32'(bus0.rsp_valid), 32'd0);
            check_val("busy_rst_valid1", 32'(bus1.rsp_valid), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("after_rst_valid0", 32'(bus0.rsp_valid), 32'd0);
            check_val("after_rst_valid1", 32'(bus1.rsp_valid), 32'd0);
        end
        check_val("after_rst_ready0", 32'(bus0.cmd_ready), 32'd1);
        check_val("after_rst_ready1", 32'(bus1.cmd_ready), 32'd1);
        m_acc0 = '0; m_acc1 = '0; m_off = 0; m_err = 1'b0;
        do_cmd(7'd3, '0, '0, 0, g0, g1);
        check_val("after_rst_read", g0, 32'h0);
        do_cmd(7'd2, 32'h0000_0001, 32'h0000_0003, 0, g0, g1);
        check_val("after_rst_offset0", g1, 32'h3);

        for (int k = 0; k < 60; k++) begin
            r  = $urandom_range(0, 11);
            ra = $urandom;
            rb = $urandom;
            case (r)
                0:       f7 = 7'd0;
                1, 2:    f7 = 7'd1;
                3:       f7 = 7'd3;
                4:       begin f7 = 7'd4; if ($urandom_range(0, 1) == 1) ra = {ra[31], {11{~ra[31]}}, ra[19:0]}; end
                5:       f7 = 7'd5;
                6:       f7 = 7'($urandom_range(6, 127));
                default: f7 = 7'd2;
            endcase
            do_cmd(f7, ra, rb, (k % 13 == 0) ? 2 : 0, g0, g1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
